match_controller: RTL

//  Game-flow controller that sits directly downstream of the ball/score logic in GameEngine.
//  - Consumes the ball X position and the ball refresh strobe.
//  - Detects goals, keeps both scores and decides the winner.
//  - Drives resetBall / ballEnable back to MoveBall and the scores to the BCD/7-seg path.
//  - Sequences the match: IDLE -> SERVE -> PLAY -> POINT -> SERVE/GAME_OVER, with timed serve and game-over holds.

---
 rtl/match_if.sv | 24 ++
 rtl/match_controller.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/match_if.sv
// Ball/score handshake between GameEngine ball logic and the match controller.
// The controller side uses the slave modport; the engine side uses master.
interface match_if;
  logic       ballTick;
  logic [7:0] xBallPosition;
  logic       startButton;
  logic       resetBall;
  logic       ballEnable;
  logic [3:0] leftScore;
  logic [3:0] rightScore;
  logic       lastScorer;
  logic       gameOver;
  logic [2:0] matchState;

  modport slave (
    input  ballTick, xBallPosition, startButton,
    output resetBall, ballEnable, leftScore, rightScore, lastScorer, gameOver, matchState
  );

  modport master (
    output ballTick, xBallPosition, startButton,
    input  resetBall, ballEnable, leftScore, rightScore, lastScorer, gameOver, matchState
  );
endinterface

// File: rtl/match_controller.sv
// Match sequencing for the pong engine: goal detection, scoring, serve and game-over holds.
//
// state     | meaning
// IDLE      | ball parked at centre, waiting for the first start press
// SERVE     | ball parked, counting ballTicks down before release
// PLAY      | ball moving, goals sampled on ballTick
// POINT     | single clock after a goal, decides next serve or match end
// GAME_OVER | winner shown, start ignored until the hold count expires
module match_controller #(
  parameter int WIN_SCORE         = 11,
  parameter int SERVE_DELAY_TICKS = 140,
  parameter int GAMEOVER_TICKS    = 420,
  parameter int LEFT_GOAL_X       = 5,
  parameter int RIGHT_GOAL_X      = 230
) (
  input logic    clock,
  input logic    reset,
  match_if.slave bus
);

  localparam int CNT_MAX = (SERVE_DELAY_TICKS > GAMEOVER_TICKS) ? SERVE_DELAY_TICKS : GAMEOVER_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_DELAY_TICKS);
  localparam logic [CW-1:0] GO_LOAD    = CW'(GAMEOVER_TICKS);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [7:0]    LEFT_X     = 8'(LEFT_GOAL_X);
  localparam logic [7:0]    RIGHT_X    = 8'(RIGHT_GOAL_X);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] tick_count, tick_count_n;
  logic [3:0]    left_score, left_score_n;
  logic [3:0]    right_score, right_score_n;
  logic          last_scorer, last_scorer_n;
  logic          sync1, sync2, start_prev;
  logic          start_press;
  logic          reset_ball_q, ball_enable_q, game_over_q;

  // Key is active-low; the synchroniser idles high so reset never fakes a press.
  assign start_press = start_prev & ~sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      tick_count    <= '0;
      left_score    <= '0;
      right_score   <= '0;
      last_scorer   <= 1'b0;
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      start_prev    <= 1'b1;
      reset_ball_q  <= 1'b1;
      ball_enable_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      sync1         <= bus.startButton;
      sync2         <= sync1;
      start_prev    <= sync2;
      state         <= state_n;
      tick_count    <= tick_count_n;
      left_score    <= left_score_n;
      right_score   <= right_score_n;
      last_scorer   <= last_scorer_n;
      reset_ball_q  <= (state_n != PLAY);
      ball_enable_q <= (state_n == PLAY);
      game_over_q   <= (state_n == GAME_OVER);
    end
  end

  always_comb begin
    state_n       = state;
    tick_count_n  = tick_count;
    left_score_n  = left_score;
    right_score_n = right_score;
    last_scorer_n = last_scorer;
    case (state)
      IDLE: begin
        if (start_press) begin
          left_score_n  = '0;
          right_score_n = '0;
          tick_count_n  = SERVE_LOAD;
          state_n       = SERVE;
        end
      end
      SERVE: begin
        if (bus.ballTick) begin
          if (tick_count <= CW'(1)) begin
            tick_count_n = '0;
            state_n      = PLAY;
          end else begin
            tick_count_n = tick_count - CW'(1);
          end
        end
      end
      PLAY: begin
        if (bus.ballTick) begin
          if (bus.xBallPosition >= RIGHT_X) begin
            if (left_score < WIN) left_score_n = left_score + 4'd1;
            last_scorer_n = 1'b0;
            state_n       = POINT;
          end else if (bus.xBallPosition <= LEFT_X) begin
            if (right_score < WIN) right_score_n = right_score + 4'd1;
            last_scorer_n = 1'b1;
            state_n       = POINT;
          end
        end
      end
      POINT: begin
        if ((left_score == WIN) || (right_score == WIN)) begin
          tick_count_n = GO_LOAD;
          state_n      = GAME_OVER;
        end else begin
          tick_count_n = SERVE_LOAD;
          state_n      = SERVE;
        end
      end
      GAME_OVER: begin
        if (start_press && (tick_count == '0)) begin
          left_score_n  = '0;
          right_score_n = '0;
          tick_count_n  = SERVE_LOAD;
          state_n       = SERVE;
        end else if (bus.ballTick && (tick_count != '0)) begin
          tick_count_n = tick_count - CW'(1);
        end
      end
      default: begin
        tick_count_n = '0;
        state_n      = IDLE;
      end
    endcase
  end

  assign bus.resetBall  = reset_ball_q;
  assign bus.ballEnable = ball_enable_q;
  assign bus.leftScore  = left_score;
  assign bus.rightScore = right_score;
  assign bus.lastScorer = last_scorer;
  assign bus.gameOver   = game_over_q;
  assign bus.matchState = state;

endmodule
